// File: rtl/net_frame_pkg.sv
// Shared frame constants, FSM state type and CRC step for the serial link.
// Used by both the transmitter and the far-end receiver.
package net_frame_pkg;

    localparam int ID_W       = 2;
    localparam int PAYLOAD_W  = 128;
    localparam int CRC_W      = 16;
    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
    localparam int FRAME_BITS = 150;
    // dest/src/payload section, framed by start, CRC and stop bits
    localparam int DATA_BITS  = FRAME_BITS - CRC_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_STOP,
        ST_GAP
    } frame_state_t;

    function automatic logic [CRC_W-1:0] crc_step(
        input logic [CRC_W-1:0] c,
        input logic             b
    );
        logic [CRC_W-1:0] n;
        n = {c[CRC_W-2:0], 1'b0};
        if (c[CRC_W-1] ^ b) begin
            n = n ^ CRC_POLY;
        end
        return n;
    endfunction

endpackage

// File: rtl/tx_transmitter_if.sv
// Frame request handshake between the capture logic and the transmitter.
// The master offers a frame; the slave raises tx_ready when it can take one.
interface tx_transmitter_if;
    import net_frame_pkg::*;

    logic                 tx_valid;
    logic                 tx_ready;
    logic [ID_W-1:0]      dest_id;
    logic [ID_W-1:0]      src_id;
    logic [PAYLOAD_W-1:0] payload;
    logic                 inject_err;

    modport master (
        output tx_valid, dest_id, src_id, payload, inject_err,
        input  tx_ready
    );

    modport slave (
        input  tx_valid, dest_id, src_id, payload, inject_err,
        output tx_ready
    );

endinterface

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16-CCITT register, one message bit per enabled cycle.
// init has priority over en so a new frame can restart it in any state.
module crc16_serial
    import net_frame_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_step(crc, din);
        end
    end

endmodule

// File: rtl/tx_transmitter.sv
// Serial frame transmitter: start | dest | src | payload | CRC-16 | stop, MSB-first.
// Each line bit is registered and held for CLKS_PER_BIT cycles.
module tx_transmitter
    import net_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50,
    parameter int IFG_BITS     = 4
) (
    input  logic            clk,
    input  logic            rst,
    tx_transmitter_if.slave tx,
    output logic            tx_line,
    output logic            busy,
    output logic            tx_done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_DONE = BW'(CLKS_PER_BIT - 2);
    localparam logic [7:0] DATA_LAST = 8'(DATA_BITS - 1);
    localparam logic [7:0] CRC_FIRST = 8'(CRC_W - 1);
    localparam logic [7:0] GAP_LAST  = 8'((IFG_BITS > 0) ? IFG_BITS - 1 : 0);

    frame_state_t         state, state_n;
    logic [BW-1:0]        baud, baud_n;
    logic [7:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 err, err_n;
    logic                 ready, ready_n;
    logic                 line_n, busy_n, done_n;
    logic                 crc_init, crc_en;
    logic [CRC_W-1:0]     crc;
    logic                 wrap;

    assign tx.tx_ready = ready;
    assign wrap = (baud == BAUD_LAST);

    crc16_serial u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .din  (shreg[DATA_BITS-1]),
        .crc  (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            baud    <= '0;
            idx     <= '0;
            shreg   <= '0;
            err     <= 1'b0;
            ready   <= 1'b0;
            tx_line <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            err     <= err_n;
            ready   <= ready_n;
            tx_line <= line_n;
            busy    <= busy_n;
            tx_done <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        baud_n   = wrap ? '0 : baud + 1'b1;
        idx_n    = idx;
        shreg_n  = shreg;
        err_n    = err;
        ready_n  = ready;
        line_n   = tx_line;
        busy_n   = busy;
        done_n   = 1'b0;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                baud_n  = '0;
                ready_n = 1'b1;
                if (ready && tx.tx_valid) begin
                    state_n  = ST_START;
                    shreg_n  = {tx.dest_id, tx.src_id, tx.payload};
                    err_n    = tx.inject_err;
                    idx_n    = '0;
                    ready_n  = 1'b0;
                    busy_n   = 1'b1;
                    line_n   = 1'b0;
                    crc_init = 1'b1;
                end
            end
            ST_START: begin
                if (wrap) begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                    line_n  = shreg[DATA_BITS-1];
                    shreg_n = shreg << 1;
                    crc_en  = 1'b1;
                end
            end
            ST_DATA: begin
                if (wrap) begin
                    if (idx == DATA_LAST) begin
                        state_n = ST_CRC;
                        idx_n   = CRC_FIRST;
                        line_n  = crc[CRC_W-1];
                    end else begin
                        idx_n   = idx + 8'd1;
                        line_n  = shreg[DATA_BITS-1];
                        shreg_n = shreg << 1;
                        crc_en  = 1'b1;
                    end
                end
            end
            ST_CRC: begin
                if (wrap) begin
                    if (idx == 8'd0) begin
                        state_n = ST_STOP;
                        line_n  = 1'b1;
                    end else begin
                        idx_n  = idx - 8'd1;
                        // link-test corruption touches only the final CRC bit
                        line_n = crc[4'(idx - 8'd1)] ^ (err && idx == 8'd1);
                    end
                end
            end
            ST_STOP: begin
                done_n = (baud == BAUD_DONE);
                if (wrap) begin
                    idx_n = '0;
                    if (IFG_BITS == 0) begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                        ready_n = 1'b1;
                    end else begin
                        state_n = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (wrap) begin
                    if (idx == GAP_LAST) begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                        ready_n = 1'b1;
                    end else begin
                        idx_n = idx + 8'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_transmitter.sv
// Bench for tx_transmitter: random frames against a bitwise CRC-16 frame model.
// The line is recorded per cycle after each accept and decoded at bit centres.
module tb_tx_transmitter;

    localparam int CPB    = 4;
    localparam int IFG    = 2;
    localparam int FB     = 150;
    localparam int PERIOD = (FB + IFG) * CPB + 1;
    localparam int CAPN   = 1300;

    logic clk, rst, tx_line, busy, tx_done;
    int   pass_cnt, total;

    logic ln [CAPN];
    logic bz [CAPN];
    logic rd [CAPN];
    logic dn [CAPN];

    tx_transmitter_if bus ();

    tx_transmitter #(.CLKS_PER_BIT(CPB), .IFG_BITS(IFG)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx      (bus),
        .tx_line (tx_line),
        .busy    (busy),
        .tx_done (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [15:0] crc_model(input logic [131:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 131; i >= 0; i--) begin
            c = c ^ {d[i], 15'b0};
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [149:0] model_frame(
        input logic [1:0] d, input logic [1:0] s,
        input logic [127:0] p, input logic e
    );
        logic [131:0] data;
        logic [15:0]  c;
        data = {d, s, p};
        c = crc_model(data);
        c[0] = c[0] ^ e;
        return {1'b0, data, c, 1'b1};
    endfunction

    function automatic logic [149:0] mid_bits(input int off);
        logic [149:0] b;
        for (int k = 0; k < FB; k++) b[149-k] = ln[off + k*CPB + CPB/2];
        return b;
    endfunction

    function automatic int unstable(input int off);
        int c = 0;
        for (int n = 0; n < FB*CPB; n++)
            if (ln[off+n] !== ln[off + (n/CPB)*CPB]) c++;
        return c;
    endfunction

    function automatic int count_done(input int off, input int len);
        int c = 0;
        for (int n = off; n < off + len; n++) if (dn[n] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_done(input int off, input int len);
        for (int n = off; n < off + len; n++) if (dn[n] === 1'b1) return n - off;
        return -1;
    endfunction

    function automatic int first_ready(input int off, input int len);
        for (int n = off; n < off + len; n++) if (rd[n] === 1'b1) return n - off;
        return -1;
    endfunction

    function automatic int count_busy(input int off, input int len);
        int c = 0;
        for (int n = off; n < off + len; n++) if (bz[n] === 1'b1) c++;
        return c;
    endfunction

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            ln[i] = tx_line;
            bz[i] = busy;
            rd[i] = bus.tx_ready;
            dn[i] = tx_done;
        end
    endtask

    task automatic accept(
        input logic [1:0] d, input logic [1:0] s, input logic [127:0] p,
        input logic e, input bit hold, output bit ok
    );
        int w = 0;
        while (bus.tx_ready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        ok = (bus.tx_ready === 1'b1);
        bus.dest_id    = d;
        bus.src_id     = s;
        bus.payload    = p;
        bus.inject_err = e;
        bus.tx_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.tx_valid = 1'b0;
        bus.dest_id = '0;
        bus.src_id = '0;
        bus.payload = '0;
        bus.inject_err = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({tx_line, busy, tx_done} !== 3'b100)
            $display("FAIL reset_outputs: got %b want 100", {tx_line, busy, tx_done});
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total++;
        if (bus.tx_ready !== 1'b0)
            $display("FAIL reset_ready: got %b want 0", bus.tx_ready);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.tx_ready !== 1'b1 || tx_line !== 1'b1)
            $display("FAIL ready_after_reset: got rdy=%b line=%b want 1 1",
                     bus.tx_ready, tx_line);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        bit ok;
        logic [149:0] exp, got;
        logic [3:0] hdr;
        accept(2'd1, 2'd2, 128'hA5, 1'b0, 1'b0, ok);
        capture(612);
        exp = model_frame(2'd1, 2'd2, 128'hA5, 1'b0);
        got = mid_bits(0);
        hdr = got[148:145];
        total++;
        if (!ok) $display("FAIL basic_accept: got not ready want ready");
        else pass_cnt++;
        total++;
        if (got !== exp) $display("FAIL basic_frame: got %h want %h", got, exp);
        else pass_cnt++;
        total++;
        if (hdr !== 4'b0110) $display("FAIL basic_ids: got %b want 0110", hdr);
        else pass_cnt++;
        total++;
        if (unstable(0) !== 0)
            $display("FAIL basic_bit_hold: got %0d glitches want 0", unstable(0));
        else pass_cnt++;
        total++;
        if (first_done(0, 612) !== FB*CPB - 1 || count_done(0, 612) !== 1)
            $display("FAIL basic_done: got at %0d x%0d want at %0d x1",
                     first_done(0, 612), count_done(0, 612), FB*CPB - 1);
        else pass_cnt++;
        total++;
        if (first_ready(0, 612) !== PERIOD - 1)
            $display("FAIL basic_ready_low: got %0d want %0d",
                     first_ready(0, 612), PERIOD - 1);
        else pass_cnt++;
        total++;
        if (count_busy(0, 612) !== PERIOD - 1 || bz[PERIOD-1] !== 1'b0)
            $display("FAIL basic_busy: got %0d want %0d",
                     count_busy(0, 612), PERIOD - 1);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            bit ok;
            logic [1:0] d = 2'($urandom);
            logic [1:0] s = 2'($urandom);
            logic [127:0] p = {$urandom, $urandom, $urandom, $urandom};
            logic [149:0] exp, got;
            accept(d, s, p, 1'b0, 1'b0, ok);
            capture(612);
            exp = model_frame(d, s, p, 1'b0);
            got = mid_bits(0);
            total++;
            if (!ok || got !== exp)
                $display("FAIL random_frame%0d: got %h want %h", f, got, exp);
            else pass_cnt++;
            total++;
            if (count_done(0, 612) !== 1)
                $display("FAIL random_done%0d: got %0d want 1", f, count_done(0, 612));
            else pass_cnt++;
        end
    endtask

    task automatic test_inject();
        bit ok;
        logic [1:0] d = 2'($urandom);
        logic [1:0] s = 2'($urandom);
        logic [127:0] p = {$urandom, $urandom, $urandom, $urandom};
        logic [149:0] got, diff, crc_lsb;
        crc_lsb = 150'd2;
        accept(d, s, p, 1'b1, 1'b0, ok);
        capture(612);
        got = mid_bits(0);
        diff = got ^ model_frame(d, s, p, 1'b0);
        total++;
        if (!ok || got !== model_frame(d, s, p, 1'b1))
            $display("FAIL inject_frame: got %h want %h", got, model_frame(d, s, p, 1'b1));
        else pass_cnt++;
        total++;
        if (diff !== crc_lsb) $display("FAIL inject_only_lsb: got %h want %h", diff, crc_lsb);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int nxt;
        logic [1:0] d1 = 2'($urandom), s1 = 2'($urandom);
        logic [1:0] d2 = 2'($urandom), s2 = 2'($urandom);
        logic [127:0] p1 = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] p2 = {$urandom, $urandom, $urandom, $urandom};
        logic [149:0] g1, g2;
        accept(d1, s1, p1, 1'b0, 1'b1, ok);
        fork
            capture(1225);
            begin
                bus.dest_id = d2;
                bus.src_id = s2;
                bus.payload = p2;
                repeat (615) @(negedge clk);
                bus.tx_valid = 1'b0;
            end
        join
        nxt = -1;
        for (int n = FB*CPB; n < 1225; n++)
            if (nxt < 0 && ln[n] === 1'b0) nxt = n;
        g1 = mid_bits(0);
        g2 = mid_bits(PERIOD);
        total++;
        if (!ok || g1 !== model_frame(d1, s1, p1, 1'b0))
            $display("FAIL b2b_frame1: got %h want %h", g1, model_frame(d1, s1, p1, 1'b0));
        else pass_cnt++;
        total++;
        if (nxt !== PERIOD) $display("FAIL b2b_next_start: got %0d want %0d", nxt, PERIOD);
        else pass_cnt++;
        total++;
        if (g2 !== model_frame(d2, s2, p2, 1'b0))
            $display("FAIL b2b_frame2: got %h want %h", g2, model_frame(d2, s2, p2, 1'b0));
        else pass_cnt++;
        total++;
        if (first_ready(1, 1224) !== PERIOD - 2 || first_ready(PERIOD, 612) !== PERIOD - 1)
            $display("FAIL b2b_ready_low: got %0d,%0d want %0d,%0d",
                     first_ready(1, 1224) + 1, first_ready(PERIOD, 612),
                     PERIOD - 1, PERIOD - 1);
        else pass_cnt++;
        total++;
        if (count_done(0, 1225) !== 2 || first_done(PERIOD, 612) !== FB*CPB - 1)
            $display("FAIL b2b_done: got %0d pulses want 2", count_done(0, 1225));
        else pass_cnt++;
    endtask

    task automatic test_ignored();
        bit ok;
        logic [1:0] d = 2'($urandom), s = 2'($urandom);
        logic [127:0] p = {$urandom, $urandom, $urandom, $urandom};
        logic [149:0] got;
        accept(d, s, p, 1'b0, 1'b0, ok);
        fork
            capture(612);
            begin
                repeat (300) begin
                    @(negedge clk);
                    bus.tx_valid = 1'($urandom);
                    bus.dest_id = 2'($urandom);
                    bus.src_id = 2'($urandom);
                    bus.payload = {$urandom, $urandom, $urandom, $urandom};
                    bus.inject_err = 1'($urandom);
                end
                bus.tx_valid = 1'b0;
                bus.inject_err = 1'b0;
            end
        join
        got = mid_bits(0);
        total++;
        if (!ok || got !== model_frame(d, s, p, 1'b0))
            $display("FAIL ignored_frame: got %h want %h", got, model_frame(d, s, p, 1'b0));
        else pass_cnt++;
        total++;
        if (unstable(0) !== 0 || count_done(0, 612) !== 1)
            $display("FAIL ignored_stream: got %0d glitches %0d done want 0 1",
                     unstable(0), count_done(0, 612));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int dcnt = 0, lcnt = 0;
        logic [1:0] d = 2'($urandom), s = 2'($urandom);
        logic [127:0] p = {$urandom, $urandom, $urandom, $urandom};
        logic [149:0] got;
        accept(d, s, p, 1'b0, 1'b0, ok);
        repeat (299) @(negedge clk);
        total++;
        if (!ok || busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total++;
        if ({tx_line, busy, bus.tx_ready} !== 3'b100)
            $display("FAIL rstmid_async: got %b want 100", {tx_line, busy, bus.tx_ready});
        else pass_cnt++;
        repeat (20) begin
            @(negedge clk);
            if (tx_done !== 1'b0) dcnt++;
            if (tx_line !== 1'b1) lcnt++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_done !== 1'b0) dcnt++;
            if (tx_line !== 1'b1) lcnt++;
        end
        total++;
        if (dcnt !== 0 || lcnt !== 0)
            $display("FAIL rstmid_abort: got done=%0d low=%0d want 0 0", dcnt, lcnt);
        else pass_cnt++;
        total++;
        if (bus.tx_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", bus.tx_ready);
        else pass_cnt++;
        d = 2'($urandom);
        s = 2'($urandom);
        p = {$urandom, $urandom, $urandom, $urandom};
        accept(d, s, p, 1'b0, 1'b0, ok);
        capture(612);
        got = mid_bits(0);
        total++;
        if (!ok || got !== model_frame(d, s, p, 1'b0))
            $display("FAIL rstmid_next_frame: got %h want %h", got, model_frame(d, s, p, 1'b0));
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total = 0;
        test_reset();
        test_basic();
        test_random();
        test_inject();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
